// File: rtl/event_dispatcher.sv
// Event/response dispatcher for the ECD message stream: buffers type-1 responses
// in a first-word-fall-through FIFO and decodes type-2 events into strobes and counters.
module event_dispatcher #(
    parameter int DATA_WIDTH  = 256,
    parameter int EVENT_COUNT = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ignore_rx,
    input  logic [EVENT_COUNT-1:0]           event_mask,
    input  logic                             clear_counts,
    output logic [EVENT_COUNT-1:0]           event_strobe,
    output logic [EVENT_COUNT*CNT_WIDTH-1:0] event_counts,
    output logic                             unknown_msg,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    input  logic [DATA_WIDTH-1:0]            AXIS_IN_TDATA,
    input  logic                             AXIS_IN_TVALID,
    output logic                             AXIS_IN_TREADY,
    output logic [DATA_WIDTH-1:0]            AXIS_OUT_TDATA,
    output logic                             AXIS_OUT_TVALID,
    input  logic                             AXIS_OUT_TREADY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [7:0] MSG_RESP  = 8'd1;
    localparam logic [7:0] MSG_EVENT = 8'd2;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] val);
        logic [CNT_WIDTH-1:0] res;
        if (val == {CNT_WIDTH{1'b1}}) begin
            res = val;
        end else begin
            res = val + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic                   armed_r;
    logic [LVL_W-1:0]       level_r;
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       rd_ptr_r;
    logic [DATA_WIDTH-1:0]  mem_r [FIFO_DEPTH];
    logic [CNT_WIDTH-1:0]   cnt_r [EVENT_COUNT];
    logic [EVENT_COUNT-1:0] strobe_r;
    logic                   unknown_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   take_s;
    logic                   out_valid_s;
    logic                   push_s;
    logic                   pop_s;
    logic                   unknown_s;
    logic [7:0]             msg_type_s;
    logic [7:0]             evt_type_s;
    logic [EVENT_COUNT-1:0] evt_dec_s;
    logic [EVENT_COUNT-1:0] evt_hit_s;

    // Ready depends only on registered state so no input-to-ready path exists.
    assign in_ready_s  = armed_r & (level_r < LVL_W'(FIFO_DEPTH));
    assign accept_s    = AXIS_IN_TVALID & in_ready_s;
    assign take_s      = accept_s & ~ignore_rx;
    assign out_valid_s = (level_r != {LVL_W{1'b0}});
    assign pop_s       = out_valid_s & AXIS_OUT_TREADY;
    assign msg_type_s  = AXIS_IN_TDATA[7:0];
    assign evt_type_s  = AXIS_IN_TDATA[15:8];

    // One-hot decode of the event type; all-zero when the type is out of range.
    always_comb begin
        evt_dec_s = {EVENT_COUNT{1'b0}};
        for (int i = 0; i < EVENT_COUNT; i++) begin
            evt_dec_s[i] = (evt_type_s == 8'(i + 1));
        end
    end

    // Classify an accepted, non-ignored beat.
    always_comb begin
        push_s    = 1'b0;
        unknown_s = 1'b0;
        evt_hit_s = {EVENT_COUNT{1'b0}};
        if (take_s) begin
            case (msg_type_s)
                MSG_RESP: begin
                    push_s = 1'b1;
                end
                MSG_EVENT: begin
                    if (|evt_dec_s) begin
                        evt_hit_s = evt_dec_s;
                    end else begin
                        unknown_s = 1'b1;
                    end
                end
                default: begin
                    unknown_s = 1'b1;
                end
            endcase
        end else begin
            push_s    = 1'b0;
            unknown_s = 1'b0;
            evt_hit_s = {EVENT_COUNT{1'b0}};
        end
    end

    // Arm flop delays the first ready until one clock after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            armed_r <= 1'b0;
        end else begin
            armed_r <= 1'b1;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally as depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because validity comes from the level.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= AXIS_IN_TDATA;
        end
    end

    // Registered event strobes and unknown-message pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_r  <= {EVENT_COUNT{1'b0}};
            unknown_r <= 1'b0;
        end else begin
            strobe_r  <= evt_hit_s & ~event_mask;
            unknown_r <= unknown_s;
        end
    end

    // Per-event saturating counters; a coincident event after a clear leaves a count of one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < EVENT_COUNT; i++) begin
                cnt_r[i] <= {CNT_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < EVENT_COUNT; i++) begin
                if (clear_counts) begin
                    cnt_r[i] <= evt_hit_s[i] ? CNT_WIDTH'(1) : {CNT_WIDTH{1'b0}};
                end else if (evt_hit_s[i]) begin
                    cnt_r[i] <= sat_inc(cnt_r[i]);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Flatten counters onto the output bus.
    always_comb begin
        event_counts = {(EVENT_COUNT*CNT_WIDTH){1'b0}};
        for (int i = 0; i < EVENT_COUNT; i++) begin
            event_counts[i*CNT_WIDTH +: CNT_WIDTH] = cnt_r[i];
        end
    end

    assign event_strobe    = strobe_r;
    assign unknown_msg     = unknown_r;
    assign fifo_level      = level_r;
    assign AXIS_IN_TREADY  = in_ready_s;
    assign AXIS_OUT_TVALID = out_valid_s;
    assign AXIS_OUT_TDATA  = out_valid_s ? mem_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};

endmodule
